// File: rtl/tetris_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tetris_input_ctrl
// Description : Command front end for the tetris1 game core. Synchronises,
//               debounces and edge-detects the raw player buttons. Generates
//               auto-repeat for held Left/Right/Down and a score-dependent
//               gravity tick. Issues at most one movement command per cycle,
//               using priority Rotate > Left > Right > Down.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i             in   1  system clock, rising edge
//   rst_i             in   1  asynchronous active-high reset
//   btn_*_i           in   1  raw asynchronous buttons, active-high
//   play_i            in   1  piece in play (enables movement and gravity)
//   score_i           in   8  current score
//   left_o/right_o/
//   down_o/rotate_o   out  1  registered single-cycle movement commands
//   start_o/
//   try_again_o       out  1  registered single-cycle control pulses
//   level_o           out  4  current gravity level
// ============================================================================
module tetris_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_RATE     = 3,
  parameter int GRAVITY_BASE    = 32,
  parameter int GRAVITY_STEP    = 2,
  parameter int GRAVITY_MIN     = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  input  logic       btn_down_i,
  input  logic       btn_rotate_i,
  input  logic       btn_start_i,
  input  logic       btn_try_again_i,
  input  logic       play_i,
  input  logic [7:0] score_i,
  output logic       left_o,
  output logic       right_o,
  output logic       down_o,
  output logic       rotate_o,
  output logic       start_o,
  output logic       try_again_o,
  output logic [3:0] level_o
);

  // Button indices; the three repeating buttons occupy the low indices so the
  // repeat generator can be selected with a single range test.
  localparam int c_BTN_LEFT   = 0;
  localparam int c_BTN_RIGHT  = 1;
  localparam int c_BTN_DOWN   = 2;
  localparam int c_BTN_ROTATE = 3;
  localparam int c_BTN_START  = 4;
  localparam int c_BTN_TRY    = 5;
  localparam int c_NBTN       = 6;
  localparam int c_NRPT       = 3;

  // Movement command indices for pending flags and grants.
  localparam int c_MV_LEFT  = 0;
  localparam int c_MV_RIGHT = 1;
  localparam int c_MV_DOWN  = 2;
  localparam int c_MV_ROT   = 3;

  localparam int c_DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_RPT_MAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int c_RPT_W     = $clog2(c_RPT_MAX + 1);
  localparam logic [11:0] c_DEC_LIMIT = 12'(GRAVITY_BASE - GRAVITY_MIN);

  logic [c_NBTN-1:0] w_btn_raw;
  logic [c_NBTN-1:0] w_press;
  logic [c_NRPT-1:0] w_fire;

  assign w_btn_raw = {btn_try_again_i, btn_start_i, btn_rotate_i,
                      btn_down_i, btn_right_i, btn_left_i};

  // --------------------------------------------------------------------------
  // Per-button synchroniser, debouncer, press detector and (for movement
  // buttons other than rotate) auto-repeat timer.
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < c_NBTN; gi++) begin : g_btn
      logic              sync1_q;
      logic              sync2_q;
      logic              deb_q;
      logic              deb_d;
      logic              press_q;
      logic [c_DB_W-1:0] cnt_q;
      logic [c_DB_W-1:0] cnt_d;

      // The counter only advances while the synchronised sample disagrees with
      // the accepted level; any agreeing sample restarts the qualification.
      always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync2_q != deb_q) begin
          if (cnt_q == c_DB_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_d = sync2_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          cnt_q   <= '0;
          deb_q   <= 1'b0;
          press_q <= 1'b0;
        end else begin
          sync1_q <= w_btn_raw[gi];
          sync2_q <= sync1_q;
          cnt_q   <= cnt_d;
          deb_q   <= deb_d;
          press_q <= deb_d & ~deb_q;
        end
      end

      assign w_press[gi] = press_q;

      if (gi < c_NRPT) begin : g_rpt
        // rcnt_q holds the number of cycles elapsed since the press (first
        // interval) or since the previous repeat (later intervals).
        logic [c_RPT_W-1:0] rcnt_q;
        logic [c_RPT_W-1:0] rcnt_d;
        logic               first_q;
        logic               first_d;
        logic               fire;

        always_comb begin
          rcnt_d  = '0;
          first_d = 1'b0;
          fire    = 1'b0;
          if (press_q) begin
            rcnt_d  = c_RPT_W'(1);
            first_d = 1'b1;
          end else if (deb_q) begin
            first_d = first_q;
            if (( first_q && (rcnt_q == c_RPT_W'(REPEAT_DELAY))) ||
                (!first_q && (rcnt_q == c_RPT_W'(REPEAT_RATE)))) begin
              fire    = 1'b1;
              rcnt_d  = c_RPT_W'(1);
              first_d = 1'b0;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) begin
            rcnt_q  <= '0;
            first_q <= 1'b0;
          end else begin
            rcnt_q  <= rcnt_d;
            first_q <= first_d;
          end
        end

        assign w_fire[gi] = fire;
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Level and gravity period
  // --------------------------------------------------------------------------
  logic [3:0]  level_q;
  logic [3:0]  level_d;
  logic [7:0]  w_lvl_raw;
  logic [11:0] w_dec;
  logic [7:0]  w_period;

  assign w_lvl_raw = score_i >> 4;
  assign level_d   = (w_lvl_raw > 8'd15) ? 4'd15 : w_lvl_raw[3:0];

  // Clamp is decided on the reduction before subtracting, so the 8-bit
  // subtraction below can never wrap.
  assign w_dec = {8'd0, level_q} * 12'(GRAVITY_STEP);

  always_comb begin
    w_period = 8'(GRAVITY_MIN);
    if (w_dec < c_DEC_LIMIT) begin
      w_period = 8'(GRAVITY_BASE) - w_dec[7:0];
    end
  end

  // --------------------------------------------------------------------------
  // Gravity counter. Compare with >= so that a shortened period takes effect
  // on a counter that is already past the new terminal value.
  // --------------------------------------------------------------------------
  logic [7:0] grv_q;
  logic [7:0] grv_d;
  logic       w_grav_evt;
  logic [3:0] w_grant;

  assign w_grav_evt = play_i && (grv_q >= (w_period - 8'd1));

  always_comb begin
    grv_d = grv_q + 8'd1;
    if (!play_i || w_grav_evt || w_grant[c_MV_DOWN]) begin
      grv_d = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Pending flags and fixed-priority arbitration. New events join the
  // candidate set in the same cycle so uncontended commands see no extra
  // latency; an event on an already-pending command simply ORs away.
  // --------------------------------------------------------------------------
  logic [3:0] pend_q;
  logic [3:0] pend_d;
  logic [3:0] w_mv_evt;
  logic [3:0] w_cand;

  assign w_mv_evt[c_MV_LEFT]  = w_press[c_BTN_LEFT]  | w_fire[c_BTN_LEFT];
  assign w_mv_evt[c_MV_RIGHT] = w_press[c_BTN_RIGHT] | w_fire[c_BTN_RIGHT];
  assign w_mv_evt[c_MV_DOWN]  = w_press[c_BTN_DOWN]  | w_fire[c_BTN_DOWN] | w_grav_evt;
  assign w_mv_evt[c_MV_ROT]   = w_press[c_BTN_ROTATE];

  always_comb begin
    w_cand  = '0;
    w_grant = '0;
    pend_d  = '0;
    if (play_i) begin
      w_cand = pend_q | w_mv_evt;
      if (w_cand[c_MV_ROT]) begin
        w_grant[c_MV_ROT] = 1'b1;
      end else if (w_cand[c_MV_LEFT]) begin
        w_grant[c_MV_LEFT] = 1'b1;
      end else if (w_cand[c_MV_RIGHT]) begin
        w_grant[c_MV_RIGHT] = 1'b1;
      end else if (w_cand[c_MV_DOWN]) begin
        w_grant[c_MV_DOWN] = 1'b1;
      end
      pend_d = w_cand & ~w_grant;
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  logic left_q;
  logic right_q;
  logic down_q;
  logic rotate_q;
  logic start_q;
  logic try_again_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q     <= '0;
      grv_q       <= '0;
      pend_q      <= '0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      down_q      <= 1'b0;
      rotate_q    <= 1'b0;
      start_q     <= 1'b0;
      try_again_q <= 1'b0;
    end else begin
      level_q     <= level_d;
      grv_q       <= grv_d;
      pend_q      <= pend_d;
      left_q      <= w_grant[c_MV_LEFT];
      right_q     <= w_grant[c_MV_RIGHT];
      down_q      <= w_grant[c_MV_DOWN];
      rotate_q    <= w_grant[c_MV_ROT];
      start_q     <= w_press[c_BTN_START];
      try_again_q <= w_press[c_BTN_TRY];
    end
  end

  assign left_o      = left_q;
  assign right_o     = right_q;
  assign down_o      = down_q;
  assign rotate_o    = rotate_q;
  assign start_o     = start_q;
  assign try_again_o = try_again_q;
  assign level_o     = level_q;

endmodule
`default_nettype wire

// File: tb/tb_tetris_input_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_tetris_input_ctrl
// Description : Scoreboard bench for tetris_input_ctrl. Stimulus pushes the
//               hand-computed pulse pattern and edge number of every expected
//               output; a monitor pops one entry per observed output pulse.
//               Edge numbers count rising clock edges after reset release.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tetris_input_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       b_left, b_right, b_down, b_rotate, b_start, b_try;
  logic       play;
  logic [7:0] score;
  logic       left_o, right_o, down_o, rotate_o, start_o, try_again_o;
  logic [3:0] level_o;

  tetris_input_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .btn_left_i      (b_left),
    .btn_right_i     (b_right),
    .btn_down_i      (b_down),
    .btn_rotate_i    (b_rotate),
    .btn_start_i     (b_start),
    .btn_try_again_i (b_try),
    .play_i          (play),
    .score_i         (score),
    .left_o          (left_o),
    .right_o         (right_o),
    .down_o          (down_o),
    .rotate_o        (rotate_o),
    .start_o         (start_o),
    .try_again_o     (try_again_o),
    .level_o         (level_o)
  );

  always #5 clk = ~clk;

  // Pulse vector order: {start, try_again, rotate, left, right, down}
  localparam logic [5:0] c_ST  = 6'b100000;
  localparam logic [5:0] c_TRY = 6'b010000;
  localparam logic [5:0] c_ROT = 6'b001000;
  localparam logic [5:0] c_L   = 6'b000100;
  localparam logic [5:0] c_R   = 6'b000010;
  localparam logic [5:0] c_D   = 6'b000001;

  typedef struct packed {
    int         at;
    logic [5:0] vec;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         cyc    = 0;
  int         base   = 0;
  int         checks = 0;
  int         errors = 0;
  logic [5:0] w_obs;

  assign w_obs = {start_o, try_again_o, rotate_o, left_o, right_o, down_o};

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && w_obs != 6'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse edge %0d got %b expected none", cyc - base, w_obs);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.at != cyc || mon_e.vec != w_obs) begin
          errors++;
          $display("FAIL pulse edge %0d got %b expected %b at edge %0d",
                   cyc - base, w_obs, mon_e.vec, mon_e.at - base);
        end
      end
    end
  end

  task automatic go(input int n);
    while (cyc < base + n) @(negedge clk);
  endtask

  task automatic expect_at(input int n, input logic [5:0] v);
    exp_t e;
    e.at  = base + n;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic end_phase(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing got %0d outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic set_btns(input logic [5:0] v);
    {b_start, b_try, b_rotate, b_left, b_right, b_down} = v;
  endtask

  task automatic do_reset(input logic [5:0] btns, input logic pl, input logic [7:0] sc);
    @(negedge clk);
    rst = 1'b1;
    set_btns(btns);
    play  = pl;
    score = sc;
    repeat (3) @(negedge clk);
    rst  = 1'b0;
    base = cyc;
  endtask

  initial begin
    rst   = 1'b1;
    play  = 1'b0;
    score = 8'd0;
    set_btns(6'b0);
    repeat (2) @(negedge clk);

    // ---- Reset with every button held ------------------------------------
    set_btns(6'b111111);
    play  = 1'b1;
    score = 8'd255;
    repeat (2) @(negedge clk);
    check_val("reset_outputs", int'(w_obs), 0);
    check_val("reset_level", int'(level_o), 0);
    @(negedge clk);
    check_val("reset_outputs_hold", int'(w_obs), 0);
    score = 8'd0;
    rst   = 1'b0;
    base  = cyc;
    expect_at(7,  c_ST | c_TRY | c_ROT);
    expect_at(8,  c_L);
    expect_at(9,  c_R);
    expect_at(10, c_D);
    expect_at(15, c_L);
    expect_at(16, c_R);
    expect_at(17, c_D);
    go(11);
    set_btns(6'b0);
    go(30);
    end_phase("reset_release");

    // ---- Debounce: 3-cycle glitch ignored, long press gives one Rotate ----
    do_reset(6'b0, 1'b1, 8'd0);
    b_rotate = 1'b1;
    go(3);
    b_rotate = 1'b0;
    go(10);
    b_rotate = 1'b1;
    expect_at(17, c_ROT);
    expect_at(32, c_D);
    go(30);
    b_rotate = 1'b0;
    go(45);
    end_phase("debounce");

    // ---- Auto-repeat on held Left ----------------------------------------
    do_reset(6'b0, 1'b1, 8'd0);
    b_left = 1'b1;
    expect_at(7,  c_L);
    expect_at(15, c_L);
    expect_at(18, c_L);
    expect_at(21, c_L);
    expect_at(24, c_L);
    expect_at(32, c_D);
    go(20);
    b_left = 1'b0;
    go(40);
    end_phase("autorepeat");

    // ---- Gravity rate vs. level, clamping, and play gating ----------------
    do_reset(6'b0, 1'b1, 8'd0);
    expect_at(32,  c_D);
    expect_at(64,  c_D);
    expect_at(86,  c_D);
    expect_at(102, c_D);
    expect_at(106, c_D);
    expect_at(110, c_D);
    expect_at(114, c_D);
    expect_at(118, c_D);
    expect_at(144, c_D);
    expect_at(148, c_D);
    go(1);
    check_val("level_score0", int'(level_o), 0);
    go(64);
    score = 8'd80;
    check_val("level_latency", int'(level_o), 0);
    go(65);
    check_val("level_score80", int'(level_o), 5);
    go(100);
    score = 8'd255;
    go(101);
    check_val("level_score255", int'(level_o), 15);
    go(119);
    play = 1'b0;
    go(140);
    play = 1'b1;
    go(149);
    play = 1'b0;
    go(160);
    end_phase("gravity");

    // ---- Contention with a coincident gravity event and manual Down -------
    do_reset(6'b0, 1'b1, 8'd0);
    go(25);
    set_btns(c_ROT | c_L | c_R | c_D);
    expect_at(32, c_ROT);
    expect_at(33, c_L);
    expect_at(34, c_R);
    expect_at(35, c_D);
    expect_at(67, c_D);
    go(31);
    set_btns(6'b0);
    go(70);
    end_phase("contention");

    // ---- Start passes while play=0, Left is suppressed -------------------
    do_reset(6'b0, 1'b0, 8'd0);
    b_start = 1'b1;
    b_left  = 1'b1;
    expect_at(7, c_ST);
    go(10);
    set_btns(6'b0);
    go(30);
    play = 1'b1;
    go(45);
    end_phase("start_gating");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tetris_input_ctrl.md
# tetris_input_ctrl

Command front end for the tetris1 game core. It synchronises, debounces and edge-detects the raw player buttons, and generates auto-repeat for held movement buttons. It also produces the gravity tick, whose rate increases with score. Its outputs drive tetris1's Start, try_again, Left, Right, Down and Rotate inputs as single-cycle pulses, with at most one movement command per cycle.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required to accept a level change.
- REPEAT_DELAY, 8: cycles from press pulse to first auto-repeat pulse.
- REPEAT_RATE, 3: cycles between subsequent auto-repeat pulses.
- GRAVITY_BASE, 32: gravity period in cycles at level 0.
- GRAVITY_STEP, 2: period reduction per level.
- GRAVITY_MIN, 4: minimum gravity period.
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- btn_left, btn_right, btn_down, btn_rotate, btn_start, btn_try_again  in  1 each  raw asynchronous buttons, active-high.
- play  in  1  high while a piece is in play (movement and gravity enabled).
- score  in  8  current score from tetris1.
- Left, Right, Down, Rotate  out  1 each  registered single-cycle movement commands.
- Start, try_again  out  1 each  registered single-cycle control pulses.
- level  out  4  current gravity level.

## Operation
- **Synchronisation.** Every button passes through a 2-flop synchroniser.
- **Debounce.** Each button has its own counter. The debounced level takes the synchronised value only after DEBOUNCE_CYCLES consecutive samples that differ from the current debounced level. Any sample that matches the current level clears the counter.
- **Press event.** Generated on a debounced 0->1 transition.
- **Auto-repeat.** Applies to left, right and down only.
  - While the debounced level stays high, a repeat event fires REPEAT_DELAY cycles after the press event, then every REPEAT_RATE cycles.
  - Release stops repeating immediately.
  - Rotate, start and try_again never repeat.
- **Level.** level = min(15, score >> 4).
- **Gravity period.** period = max(GRAVITY_MIN, GRAVITY_BASE - level*GRAVITY_STEP). Compute in 8 bits and clamp before any subtraction can underflow.
- **Gravity counter.** Counts only while play=1 and raises a gravity event when it reaches period-1. It clears to 0 on:
  - the gravity event itself;
  - play=0;
  - any cycle in which Down is issued, manual or gravity.
- **Pending flags.** Each movement command has a one-deep pending flag, set by its press, repeat or gravity event.
  - A new event for a command that is already pending is merged and dropped.
  - Gravity and manual down share one pending flag.
- **Arbitration.** Each cycle, issue the highest-priority pending command and clear its flag. Priority is Rotate > Left > Right > Down.
- **play=0.** All movement pending flags clear, movement events are dropped, and no movement outputs assert.
- **Start and try_again.** Not arbitrated and not gated by play. Each asserts for one cycle per press event.

## Timing
- **Reset values.** All outputs 0, level 0. All synchronisers, debounced levels, counters and pending flags are 0.
- **Reset mid-operation.** Clears immediately and asynchronously. No pulse is produced during reset. A button held through reset release produces one press event, with normal latency counted from the first clock after release.
- **Press-to-output latency.** DEBOUNCE_CYCLES+3 cycles from the first clock edge that samples the raw high, when uncontended (7 cycles at default).
- **Contention.** A contended command is delayed by one cycle per higher-priority command issued ahead of it.
- **Pulse width.** Exactly one cycle per issued command. Two issued commands are never back-to-back for the same pending entry without a new event.
- **Glitches.** A raw pulse shorter than DEBOUNCE_CYCLES synchronised samples produces no output.
- **Level changes.** level follows score with 1-cycle register latency. A period change takes effect on the running counter immediately. If the counter is already at or above the new period-1, the gravity event fires on the next cycle.

## Test plan
- **Reset.** Reset=1 with all buttons high -> all outputs 0. Release Reset -> exactly one each of Rotate, Start and try_again, plus Left, Right and Down press pulses and repeats, issued in priority order.
- **Debounce.** With default parameters, btn_rotate high for 3 cycles then low -> no Rotate. High for 20 cycles -> one Rotate pulse, 7 cycles after the rise.
- **Auto-repeat.** Hold btn_left for 20 cycles, play=1 -> Left at t, t+8, t+11, t+14, t+17; none after release.
- **Gravity rate.** play=1, no buttons:
  - score=0 -> Down every 32 cycles.
  - score=80 -> level 5, Down every 22 cycles.
  - score=255 -> level 15, Down every 4 cycles (clamped).
  - Drop play -> Down stops and the counter restarts from 0 when play returns.
- **Contention.** btn_rotate, btn_left and btn_right debounce high on the same cycle -> Rotate, Left, Right on three consecutive cycles. A gravity event in that window is deferred to the following cycle, and a manual Down merges with it into a single Down.
- **Start/try_again gating.** play=0 with btn_start and btn_left pressed -> Start pulse only; no Left.
